// File: rtl/debug_ocimem_pkg.sv
// Shared types and jdo field positions for the OCI memory debug sequencer.
package debug_ocimem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int JDO_CLR_ERR   = 33;
    localparam int JDO_LD_ADDR   = 34;
    localparam int JDO_RD        = 35;
    localparam int JDO_ADDR_LSB  = 17;
    localparam int JDO_WDATA_LSB = 3;
    localparam int DATA_W        = 32;

endpackage

// File: rtl/debug_ocimem_timeout.sv
// Saturating up-counter for the memory request wait; expired_o flags count == TIMEOUT.
module debug_ocimem_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired_o = (cnt_q == CNT_W'(TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/debug_ocimem_sequencer.sv
// Sequences single-beat OCI RAM reads/writes from debug-slave take_* pulses,
// auto-incrementing the address and reporting MonDReg / ready / sticky error.
//
// state | meaning
// IDLE  | monitor_ready high, decoding take_* pulses
// REQ   | mem_req held until mem_ack or timeout
// DONE  | one-cycle settle before returning to IDLE
module debug_ocimem_sequencer
    import debug_ocimem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [37:0]         jdo,
    input  logic                take_action_ocimem_a,
    input  logic                take_action_ocimem_b,
    input  logic                take_no_action_ocimem_a,
    input  logic                debugack,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [DATA_W-1:0]   MonDReg,
    output logic                monitor_ready,
    output logic                monitor_error
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   mon_q, mon_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic                err_set, err_clr;
    logic                cnt_clr, cnt_en, expired;
    logic                any_take;
    logic                jdo_unused;

    // jdo bits outside the command fields carry nothing for this block.
    assign jdo_unused = ^{jdo[37:36], jdo[2:0]};

    assign any_take = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    debug_ocimem_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr_i     (cnt_clr),
        .en_i      (cnt_en),
        .expired_o (expired)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        mon_d   = mon_q;
        ready_d = ready_q;
        err_set = 1'b0;
        err_clr = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (take_action_ocimem_b) begin
                    if (debugack) begin
                        we_d    = 1'b1;
                        wdata_d = jdo[JDO_WDATA_LSB +: DATA_W];
                        ready_d = 1'b0;
                        state_d = REQ;
                    end else begin
                        err_set = 1'b1;
                    end
                end else if (take_action_ocimem_a) begin
                    err_clr = jdo[JDO_CLR_ERR];
                    if (jdo[JDO_LD_ADDR]) begin
                        addr_d = jdo[JDO_ADDR_LSB +: ADDR_W];
                    end
                    if (jdo[JDO_RD]) begin
                        we_d    = 1'b0;
                        ready_d = 1'b0;
                        state_d = REQ;
                    end
                end else if (take_no_action_ocimem_a) begin
                    we_d    = 1'b0;
                    ready_d = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                cnt_en  = 1'b1;
                err_set = any_take;
                // An ack on the expiry cycle still wins over the timeout.
                if (mem_ack) begin
                    if (!we_q) begin
                        mon_d = mem_rdata;
                    end
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = DONE;
                end else if (expired) begin
                    err_set = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                err_set = any_take;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase

        // A clear and a fresh error in the same cycle leave the flag set.
        err_d = (err_q & ~err_clr) | err_set;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            mon_q   <= '0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            mon_q   <= mon_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign mem_req       = (state_q == REQ);
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign MonDReg       = mon_q;
    assign monitor_ready = ready_q;
    assign monitor_error = err_q;

endmodule

// File: tb/tb_debug_ocimem_sequencer.sv
// Bench for debug_ocimem_sequencer: transaction-level model compared every cycle plus literal checks.
module tb_debug_ocimem_sequencer;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [37:0]       jdo;
    logic              take_a, take_b, take_na;
    logic              debugack;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic [31:0]       MonDReg;
    logic              monitor_ready, monitor_error;

    int n_tests = 0;
    int n_fail  = 0;

    debug_ocimem_sequencer #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_action_ocimem_b    (take_b),
        .take_no_action_ocimem_a (take_na),
        .debugack                (debugack),
        .mem_req                 (mem_req),
        .mem_we                  (mem_we),
        .mem_addr                (mem_addr),
        .mem_wdata               (mem_wdata),
        .mem_ack                 (mem_ack),
        .mem_rdata               (mem_rdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: an access is either absent, pending (waited cycles counted), or finishing.
    int          m_phase;   // 0 none, 1 pending, 2 finishing
    int          m_wait;
    logic [7:0]  m_addr;
    logic        m_we;
    logic [31:0] m_wdata;
    logic [31:0] m_mon;
    logic        m_err;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = 0; m_wait = 0; m_addr = 8'h00; m_we = 1'b0;
            m_wdata = 32'h0; m_mon = 32'h0; m_err = 1'b0;
        end else if (m_phase == 0) begin
            if (take_b) begin
                if (debugack) begin
                    m_we = 1'b1; m_wdata = jdo[34:3]; m_phase = 1; m_wait = 0;
                end else begin
                    m_err = 1'b1;
                end
            end else if (take_a) begin
                if (jdo[33]) m_err = 1'b0;
                if (jdo[34]) m_addr = jdo[24:17];
                if (jdo[35]) begin m_we = 1'b0; m_phase = 1; m_wait = 0; end
            end else if (take_na) begin
                m_we = 1'b0; m_phase = 1; m_wait = 0;
            end
        end else if (m_phase == 1) begin
            if (take_a || take_b || take_na) m_err = 1'b1;
            if (mem_ack) begin
                if (!m_we) m_mon = mem_rdata;
                m_addr  = m_addr + 8'd1;
                m_phase = 2;
            end else if (m_wait == TIMEOUT) begin
                m_err   = 1'b1;
                m_phase = 2;
            end else begin
                m_wait++;
            end
        end else begin
            if (take_a || take_b || take_na) m_err = 1'b1;
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("cyc_req",   mem_req,       m_phase == 1);
            chk("cyc_ready", monitor_ready, m_phase == 0);
            chk("cyc_err",   monitor_error, m_err);
            chk("cyc_mon",   MonDReg,       m_mon);
            chk("cyc_addr",  mem_addr,      m_addr);
            if (m_phase == 1) begin
                chk("cyc_we", mem_we, m_we);
                if (m_we) chk("cyc_wdata", mem_wdata, m_wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd_a(input logic clr, input logic ld, input logic rd, input logic [7:0] a);
        jdo = '0; jdo[33] = clr; jdo[34] = ld; jdo[35] = rd; jdo[24:17] = a;
        take_a = 1'b1; tick(); take_a = 1'b0; jdo = '0;
    endtask

    task automatic cmd_b(input logic [31:0] d);
        jdo = '0; jdo[34:3] = d;
        take_b = 1'b1; tick(); take_b = 1'b0; jdo = '0;
    endtask

    task automatic cmd_na();
        take_na = 1'b1; tick(); take_na = 1'b0;
    endtask

    task automatic wait_req(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req) begin ok = 1'b1; break; end
            tick();
        end
        chk(name, ok, 1'b1);
    endtask

    task automatic ack_after(input int dly, input logic [31:0] d);
        repeat (dly) tick();
        mem_ack = 1'b1; mem_rdata = d;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
    endtask

    task automatic wait_ready(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (monitor_ready) begin ok = 1'b1; break; end
            tick();
        end
        chk(name, ok, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        reset_n = 1'b0; jdo = '0; take_a = 1'b0; take_b = 1'b0; take_na = 1'b0;
        debugack = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        #12;
        chk("rst_req",   mem_req, 1'b0);
        chk("rst_ready", monitor_ready, 1'b1);
        chk("rst_err",   monitor_error, 1'b0);
        chk("rst_mon",   MonDReg, 32'h0);
        chk("rst_addr",  mem_addr, 8'h00);
        chk("rst_we",    mem_we, 1'b0);
        chk("rst_wdata", mem_wdata, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick();

        // Load address 0x10 and read, ack two cycles later.
        cmd_a(1'b0, 1'b1, 1'b1, 8'h10);
        wait_req("t1_req");
        chk("t1_addr", mem_addr, 8'h10);
        chk("t1_we",   mem_we, 1'b0);
        ack_after(2, 32'hDEADBEEF);
        wait_ready("t1_ready");
        chk("t1_mon",  MonDReg, 32'hDEADBEEF);
        chk("t1_inc",  mem_addr, 8'h11);
        chk("t1_err",  monitor_error, 1'b0);

        // Two writes from 0xFF with wrap; also pins the 3-cycle ready latency.
        debugack = 1'b1;
        cmd_a(1'b0, 1'b1, 1'b0, 8'hFF);
        chk("t2_load", mem_addr, 8'hFF);
        cmd_b(32'h1);
        chk("t2_req1",   mem_req, 1'b1);
        chk("t2_addr1",  mem_addr, 8'hFF);
        chk("t2_we1",    mem_we, 1'b1);
        chk("t2_wdata1", mem_wdata, 32'h1);
        ack_after(0, 32'h0);
        chk("t2_ready_lo", monitor_ready, 1'b0);
        tick();
        chk("t2_latency", monitor_ready, 1'b1);
        chk("t2_wrap", mem_addr, 8'h00);
        cmd_b(32'h2);
        chk("t2_addr2",  mem_addr, 8'h00);
        chk("t2_wdata2", mem_wdata, 32'h2);
        ack_after(0, 32'h0);
        wait_ready("t2_ready");
        chk("t2_inc", mem_addr, 8'h01);
        chk("t2_mon_kept", MonDReg, 32'hDEADBEEF);

        // Write without debugack is refused.
        debugack = 1'b0;
        cmd_b(32'hBAD);
        chk("t3_noreq", mem_req, 1'b0);
        chk("t3_err",   monitor_error, 1'b1);
        tick();
        chk("t3_noreq2", mem_req, 1'b0);
        chk("t3_addr",   mem_addr, 8'h01);
        cmd_a(1'b1, 1'b0, 1'b0, 8'h00);
        chk("t3_clr", monitor_error, 1'b0);

        // Read with no ack times out after TIMEOUT+1 request cycles.
        cmd_na();
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req) hi++;
            else if (hi > 0) break;
            tick();
        end
        chk("t4_req_cycles", hi, 5);
        wait_ready("t4_ready");
        chk("t4_err",  monitor_error, 1'b1);
        chk("t4_mon",  MonDReg, 32'hDEADBEEF);
        chk("t4_addr", mem_addr, 8'h01);
        cmd_a(1'b1, 1'b0, 1'b0, 8'h00);
        cmd_na();
        ack_after(TIMEOUT, 32'hCAFEF00D);
        wait_ready("t4b_ready");
        chk("t4b_mon",  MonDReg, 32'hCAFEF00D);
        chk("t4b_err",  monitor_error, 1'b0);
        chk("t4b_addr", mem_addr, 8'h02);

        // Write pulse during an in-flight read is dropped and flagged.
        debugack = 1'b1;
        cmd_na();
        wait_req("t5_req");
        cmd_b(32'h55);
        chk("t5_still_read", mem_we, 1'b0);
        ack_after(0, 32'h12345678);
        wait_ready("t5_ready");
        chk("t5_mon",  MonDReg, 32'h12345678);
        chk("t5_err",  monitor_error, 1'b1);
        chk("t5_addr", mem_addr, 8'h03);
        tick();
        chk("t5_noreq", mem_req, 1'b0);

        // Asynchronous reset mid-request.
        cmd_a(1'b1, 1'b0, 1'b0, 8'h00);
        cmd_na();
        wait_req("t6_req");
        reset_n = 1'b0;
        #1;
        chk("t6_req_async",   mem_req, 1'b0);
        chk("t6_ready_async", monitor_ready, 1'b1);
        chk("t6_mon_async",   MonDReg, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("t6_mon",   MonDReg, 32'h0);
        chk("t6_ready", monitor_ready, 1'b1);
        chk("t6_addr",  mem_addr, 8'h00);
        chk("t6_err",   monitor_error, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
